// File: rtl/reduce_join_pkg.sv
// Shared definitions for the reduce_join stage: op encodings and the
// reduction function applied across all channel heads.
package reduce_join_pkg;

  localparam logic [1:0] OP_XOR = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  // Operands are zero-extended into a fixed-size array so one function serves
  // every WIDTH/NUM_IN; bitwise ops and modular ADD are unaffected by truncation.
  localparam int MAX_IN    = 8;
  localparam int MAX_WIDTH = 64;

  typedef logic [MAX_IN-1:0][MAX_WIDTH-1:0] operand_array_t;

  function automatic logic [MAX_WIDTH-1:0] reduce_ops(input logic [1:0] op,
                                                      input operand_array_t ops,
                                                      input int num);
    logic [MAX_WIDTH-1:0] acc;
    acc = ops[0];
    for (int i = 1; i < MAX_IN; i++) begin
      if (i < num) begin
        case (op)
          OP_XOR:  acc = acc ^ ops[i];
          OP_AND:  acc = acc & ops[i];
          OP_OR:   acc = acc | ops[i];
          default: acc = acc + ops[i];
        endcase
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/rj_fifo.sv
// Per-channel synchronous FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module rj_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/reduce_join.sv
// N-input join: buffers one operand stream per channel and emits the reduction
// of the channel heads once every channel holds data. WIDTH<=64, NUM_IN<=8.
module reduce_join
  import reduce_join_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int DEPTH  = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_en,
  output logic [NUM_IN-1:0]       in_rdy,
  input  logic [1:0]              op,
  output logic [WIDTH-1:0]        y_data,
  output logic                    y_en,
  input  logic                    y_rdy,
  output logic [15:0]             y_count
);

  logic [NUM_IN-1:0]             full;
  logic [NUM_IN-1:0]             empty;
  logic [NUM_IN-1:0][WIDTH-1:0]  heads;
  operand_array_t                operands;
  logic [WIDTH-1:0]              reduced;
  logic                          fire;

  assign in_rdy = ~full;
  assign fire   = ~|empty && (!y_en || y_rdy);

  for (genvar g = 0; g < NUM_IN; g++) begin : g_chan
    rj_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (in_en[g]),
      .push_data (in_data[g*WIDTH +: WIDTH]),
      .pop       (fire),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (heads[g])
    );
  end

  always_comb begin
    operands = '0;
    for (int i = 0; i < NUM_IN; i++) operands[i][WIDTH-1:0] = heads[i];
  end

  assign reduced = WIDTH'(reduce_ops(op, operands, NUM_IN));

  // A new result may replace the held one only when it is being taken this edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      y_data  <= '0;
      y_en    <= 1'b0;
      y_count <= '0;
    end else begin
      if (fire) begin
        y_data <= reduced;
        y_en   <= 1'b1;
      end else if (y_rdy) begin
        y_en   <= 1'b0;
      end
      if (y_en && y_rdy) y_count <= y_count + 16'd1;
    end
  end

endmodule

// File: doc/reduce_join.md
# reduce_join

Parametrised N-input join/reduce stage: accepts one WIDTH-bit operand per input channel through independent en/rdy handshakes, buffers each channel in a small FIFO, and, once every channel holds an operand, emits one reduced result (XOR/AND/OR/ADD) on a backpressured output. Successor to the single-bit two-input XOR join in the interfaces test DUT set: wider data, more channels, input buffering and selectable operation.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- NUM_IN, 2, number of input channels (2..8)
- DEPTH, 2, per-channel FIFO depth in entries (power of 2, ≥2)
- CLK  input  1  single clock, all state on rising edge
- RST_N  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*WIDTH  channel i operand in bits [i*WIDTH +: WIDTH]
- in_en  input  NUM_IN  channel i offers in_data slice this cycle
- in_rdy  output  NUM_IN  channel i FIFO can accept
- op  input  2  reduction select: 0 XOR, 1 AND, 2 OR, 3 ADD (mod 2^WIDTH)
- y_data  output  WIDTH  reduced result
- y_en  output  1  y_data valid
- y_rdy  input  1  downstream accepts y_data
- y_count  output  16  results delivered (y_en && y_rdy), wraps 0xFFFF→0

## Operation
- Channel i push: rising edge with in_en[i] && in_rdy[i]; in_data slice captured at that edge (never re-sampled later).
- in_rdy[i] = !full[i], from registered occupancy only; no pass-through when full, even if a pop happens the same cycle.
- in_en[i] while !in_rdy[i]: ignored, no state change.
- fire = all FIFOs non-empty && (!y_en || y_rdy).
- On fire: pop head of every FIFO at once; y_data <= reduce(op, heads in channel order); y_en <= 1.
- op sampled combinationally in the fire cycle only; changing op never alters an already registered y_data.
- y_en && y_rdy without fire: y_en <= 0, y_data holds last value.
- y_en && !y_rdy: y_data, y_en stable (no overwrite).
- ADD: unsigned sum of all NUM_IN operands truncated to WIDTH bits, carry discarded.
- y_count increments on each y_en && y_rdy edge.
- Occupancy per channel 0..DEPTH; push and pop same edge on non-full, non-empty FIFO: count unchanged, order preserved.

## Timing
- Reset (async assert, any cycle, mid-transfer included): all FIFOs empty, y_en 0, y_data 0, y_count 0; in_rdy all 1 (FIFOs empty). Release synchronous to CLK by the environment.
- Latency: last channel pushed at edge k → y_en high after edge k+1 (if output slot free).
- Throughput: one result per cycle with y_rdy held high and all channels streaming.
- Output full (y_en && !y_rdy) plus all FIFOs full: all in_rdy 0 until y_rdy.
- y_rdy asserted while all FIFOs non-empty: fire and drain in the same edge, y_en stays 1, new y_data.
- Channels may be skewed by up to DEPTH operands; pairing is strictly by FIFO order (n-th push of every channel reduces together).

## Structure
- Package reduce_join_pkg: op encoding constants (OP_XOR, OP_AND, OP_OR, OP_ADD) and the reduction function over a NUM_IN×WIDTH operand array.
- Sub-module rj_fifo (WIDTH, DEPTH): synchronous FIFO with push/pop/full/empty/head, wrap-around pointers plus extra bit for full/empty; instantiated NUM_IN times via generate.
- Top holds fire logic, output register, y_count.

## Test plan
- WIDTH=8, NUM_IN=2, op=0: push 0xA5 on ch0, 0x0F on ch1 same edge, y_rdy=1 → y_data 0x AA next cycle, y_en one cycle, y_count=1.
- Skew: ch0 pushes 0x01,0x02 (DEPTH=2 → in_rdy[0]=0), ch1 idle; then ch1 pushes 0x10,0x20 with op=3 → results 0x11 then 0x22 in order.
- Backpressure: y_rdy=0, fill both FIFOs plus output → all in_rdy 0, y_data stable 3+ cycles; raise y_rdy → one result per cycle until drained.
- ADD wrap: NUM_IN=4, operands 0xFF,0xFF,0x01,0x01 → y_data 0x00; op=1 on 0xF0,0xFF,0x3C,0xF3 → 0x30.
- Reset mid-operation: RST_N low while y_en=1 and FIFOs half full → y_en, y_data, y_count 0 immediately; first result after release uses only post-reset pushes.
- Stream 70000 results with y_rdy=1 → y_count wraps to 70000−65536=4464.
